// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and helpers for pipeline hazard control
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN,
        MDU_BUSY
    } hazard_state_e;

    // Priority class acting on the pipeline this cycle, highest first
    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_DMEM,
        CLS_MDU,
        CLS_REDIRECT,
        CLS_LOAD_USE
    } hazard_class_e;

    typedef struct packed {
        logic stall;
        logic flush;
    } pipe_ctrl_t;

    // A load in EX whose destination is read by the instruction in ID
    function automatic logic load_use_hit(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs1_used,
        input logic       rs2_used,
        input logic [4:0] rd,
        input logic       mem_read
    );
        return mem_read && (rd != 5'd0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush generation with MDU occupancy FSM and perf counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_rs1_used,
    input  logic             if_id_rs2_used,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_is_mdu,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             perf_clr,
    output logic             pc_stall,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             stall_id_ex,
    output logic             flush_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_ex_mem,
    output logic             stall_mem_wb,
    output logic             flush_mem_wb,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // mdu_cnt counts the remaining stall cycles after the first, so it only
    // ever holds 0 .. MDU_LATENCY-2
    localparam int CW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (MDU_LATENCY > 1) ? CW'(MDU_LATENCY - 2) : '0;
    localparam logic MULTI_CYCLE = (MDU_LATENCY > 1);
    localparam logic SINGLE_CYCLE = (MDU_LATENCY == 1);

    hazard_state_e state, state_nx;
    logic [CW-1:0] mdu_cnt, mdu_cnt_nx;
    hazard_class_e cls;
    logic          dmem_wait, mdu_start, mdu_busy, load_use;
    pipe_ctrl_t    if_id, id_ex, ex_mem, mem_wb;
    logic          pc_hold, done;

    // Classify the hazard acting this cycle by strict priority
    always_comb begin
        dmem_wait = mem_req && !dmem_ready;
        mdu_start = (state == RUN) && id_ex_is_mdu && MULTI_CYCLE;
        mdu_busy  = mdu_start || ((state == MDU_BUSY) && (mdu_cnt != '0));
        load_use  = load_use_hit(if_id_rs1, if_id_rs2, if_id_rs1_used, if_id_rs2_used,
                                 id_ex_rd, id_ex_mem_read);
        cls = dmem_wait   ? CLS_DMEM     :
              mdu_busy    ? CLS_MDU      :
              ex_redirect ? CLS_REDIRECT :
              load_use    ? CLS_LOAD_USE : CLS_NONE;
    end

    // MDU state register; a data-memory wait freezes EX so the FSM holds too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            mdu_cnt <= '0;
        end else begin
            state   <= state_nx;
            mdu_cnt <= mdu_cnt_nx;
        end
    end

    // Next state: start, count down, then return to RUN on the done cycle
    always_comb begin
        state_nx   = state;
        mdu_cnt_nx = mdu_cnt;
        if (!dmem_wait) begin
            if (mdu_start) begin
                state_nx   = MDU_BUSY;
                mdu_cnt_nx = CNT_LOAD;
            end else if (state == MDU_BUSY) begin
                state_nx   = (mdu_cnt == '0) ? RUN : MDU_BUSY;
                mdu_cnt_nx = (mdu_cnt == '0) ? mdu_cnt : mdu_cnt - 1'b1;
            end
        end
    end

    // Per-register controls from the active class; forced low while in reset
    always_comb begin
        if_id   = '{stall: (cls == CLS_DMEM) || (cls == CLS_MDU) || (cls == CLS_LOAD_USE),
                    flush: (cls == CLS_REDIRECT)};
        id_ex   = '{stall: (cls == CLS_DMEM) || (cls == CLS_MDU),
                    flush: (cls == CLS_REDIRECT) || (cls == CLS_LOAD_USE)};
        ex_mem  = '{stall: (cls == CLS_DMEM), flush: (cls == CLS_MDU)};
        mem_wb  = '{stall: 1'b0, flush: (cls == CLS_DMEM)};
        pc_hold = if_id.stall;
        done    = ((state == MDU_BUSY) && (mdu_cnt == '0)) ||
                  (SINGLE_CYCLE && (state == RUN) && id_ex_is_mdu);
        pc_stall     = rst_n && pc_hold;
        stall_if_id  = rst_n && if_id.stall;
        flush_if_id  = rst_n && if_id.flush;
        stall_id_ex  = rst_n && id_ex.stall;
        flush_id_ex  = rst_n && id_ex.flush;
        stall_ex_mem = rst_n && ex_mem.stall;
        flush_ex_mem = rst_n && ex_mem.flush;
        stall_mem_wb = rst_n && mem_wb.stall;
        flush_mem_wb = rst_n && mem_wb.flush;
        mdu_done     = rst_n && done;
    end

    // Performance counters; clear wins over increment, wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            stall_cycles <= stall_cycles + CNT_W'(pc_hold);
            flush_events <= flush_events + CNT_W'(cls == CLS_REDIRECT);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + random checks of hazard_ctrl (latency 4 and 1) against a reference model
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_used, rs2_used, mem_read, is_mdu, redirect, mem_req, dmem_ready, perf_clr;
    logic [9:0] ctrl0, ctrl1;
    logic [31:0] sc0, fe0, sc1, fe1;

    int tests = 0;
    int fails = 0;

    int          lat [2] = '{4, 1};
    int          m_left [2] = '{0, 0};
    logic [31:0] m_sc [2] = '{0, 0};
    logic [31:0] m_fe [2] = '{0, 0};
    int          n_left [2];
    logic [31:0] n_sc [2];
    logic [31:0] n_fe [2];

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used),
        .id_ex_rd(rd), .id_ex_mem_read(mem_read), .id_ex_is_mdu(is_mdu),
        .ex_redirect(redirect), .mem_req(mem_req), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
        .pc_stall(ctrl0[9]), .stall_if_id(ctrl0[8]), .flush_if_id(ctrl0[7]),
        .stall_id_ex(ctrl0[6]), .flush_id_ex(ctrl0[5]), .stall_ex_mem(ctrl0[4]),
        .flush_ex_mem(ctrl0[3]), .stall_mem_wb(ctrl0[2]), .flush_mem_wb(ctrl0[1]),
        .mdu_done(ctrl0[0]), .stall_cycles(sc0), .flush_events(fe0)
    );

    hazard_ctrl #(.MDU_LATENCY(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used),
        .id_ex_rd(rd), .id_ex_mem_read(mem_read), .id_ex_is_mdu(is_mdu),
        .ex_redirect(redirect), .mem_req(mem_req), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
        .pc_stall(ctrl1[9]), .stall_if_id(ctrl1[8]), .flush_if_id(ctrl1[7]),
        .stall_id_ex(ctrl1[6]), .flush_id_ex(ctrl1[5]), .stall_ex_mem(ctrl1[4]),
        .flush_ex_mem(ctrl1[3]), .stall_mem_wb(ctrl1[2]), .flush_mem_wb(ctrl1[1]),
        .mdu_done(ctrl1[0]), .stall_cycles(sc1), .flush_events(fe1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        rs1_used = 1'b0; rs2_used = 1'b0; mem_read = 1'b0; is_mdu = 1'b0;
        redirect = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1; perf_clr = 1'b0;
    endtask

    // Model: remaining EX occupancy of the current MDU op, counted in cycles
    task automatic check(input string tag);
        for (int k = 0; k < 2; k++) begin
            logic       dw, lu, dn, redir_act;
            logic [8:0] c;
            int         eff;
            dw  = mem_req && !dmem_ready;
            eff = (m_left[k] != 0) ? m_left[k] : (is_mdu ? lat[k] : 0);
            lu  = mem_read && rd != 5'd0 && ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
            dn  = (eff == 1);
            redir_act = 1'b0;
            if (dw)            c = 9'b110101001;
            else if (eff > 1)  c = 9'b110100100;
            else if (redirect) begin c = 9'b001010000; redir_act = 1'b1; end
            else if (lu)       c = 9'b110010000;
            else               c = 9'b000000000;
            if (!rst_n) begin
                chk($sformatf("%s/ctrl_l%0d", tag, lat[k]), {22'd0, (k == 0) ? ctrl0 : ctrl1}, 32'd0);
                chk($sformatf("%s/stall_cycles_l%0d", tag, lat[k]), (k == 0) ? sc0 : sc1, 32'd0);
                chk($sformatf("%s/flush_events_l%0d", tag, lat[k]), (k == 0) ? fe0 : fe1, 32'd0);
                n_left[k] = 0; n_sc[k] = 0; n_fe[k] = 0;
            end else begin
                chk($sformatf("%s/ctrl_l%0d", tag, lat[k]), {22'd0, (k == 0) ? ctrl0 : ctrl1}, {22'd0, c, dn});
                chk($sformatf("%s/stall_cycles_l%0d", tag, lat[k]), (k == 0) ? sc0 : sc1, m_sc[k]);
                chk($sformatf("%s/flush_events_l%0d", tag, lat[k]), (k == 0) ? fe0 : fe1, m_fe[k]);
                n_left[k] = dw ? m_left[k] : ((eff > 0) ? eff - 1 : 0);
                n_sc[k] = perf_clr ? 32'd0 : m_sc[k] + {31'd0, c[8]};
                n_fe[k] = perf_clr ? 32'd0 : m_fe[k] + {31'd0, redir_act};
            end
        end
    endtask

    // Check mid-cycle, then advance one clock and commit the model
    task automatic step(input string tag);
        #4;
        check(tag);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_left[k] = n_left[k];
            m_sc[k] = n_sc[k];
            m_fe[k] = n_fe[k];
        end
    endtask

    initial begin
        idle();
        is_mdu = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0; redirect = 1'b1;
        step("reset");
        idle();
        rst_n = 1'b1;
        step("idle");
        // load-use on rs1
        mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1; rs2 = 5'd1; rs2_used = 1'b1;
        step("lu_rs1");
        idle();
        step("lu_free");
        chk("lu_stall_cycles", sc0, 32'd1);
        // rd == x0 and unused sources must not stall
        mem_read = 1'b1; rd = 5'd0; rs1 = 5'd0; rs1_used = 1'b1;
        step("lu_x0");
        rd = 5'd7; rs1 = 5'd7; rs1_used = 1'b0; rs2 = 5'd7; rs2_used = 1'b0;
        step("lu_unused");
        rs2_used = 1'b1;
        step("lu_rs2");
        idle();
        // multi-cycle MDU op
        is_mdu = 1'b1;
        for (int i = 0; i < 4; i++) step($sformatf("mdu_%0d", i));
        idle();
        step("mdu_after");
        // redirect overrides load-use
        redirect = 1'b1; mem_read = 1'b1; rd = 5'd3; rs2 = 5'd3; rs2_used = 1'b1;
        step("redir_lu");
        idle();
        step("redir_after");
        // data-memory wait while MDU has one stall cycle left, with a deferred redirect
        is_mdu = 1'b1;
        step("mdu_w0");
        step("mdu_w1");
        mem_req = 1'b1; dmem_ready = 1'b0; redirect = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("dmem_wait_%0d", i));
        mem_req = 1'b0; dmem_ready = 1'b1;
        step("mdu_rel_0");
        step("mdu_rel_1");
        is_mdu = 1'b0;
        step("redir_deferred");
        idle();
        // async reset aborts an MDU op
        is_mdu = 1'b1;
        step("mdu_abort_0");
        step("mdu_abort_1");
        rst_n = 1'b0;
        step("mdu_abort_rst");
        rst_n = 1'b1;
        idle();
        step("after_abort");
        // clear wins over a concurrent stall increment
        mem_read = 1'b1; rd = 5'd9; rs1 = 5'd9; rs1_used = 1'b1;
        step("pre_clr");
        perf_clr = 1'b1;
        step("clr_with_stall");
        idle();
        step("post_clr");
        chk("post_clr_zero", sc0, 32'd0);
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            rs1_used   = 1'($urandom_range(0, 1));
            rs2_used   = 1'($urandom_range(0, 1));
            mem_read   = 1'($urandom_range(0, 1));
            is_mdu     = ($urandom_range(0, 3) == 0);
            redirect   = ($urandom_range(0, 5) == 0);
            mem_req    = 1'($urandom_range(0, 1));
            dmem_ready = ($urandom_range(0, 2) != 0);
            perf_clr   = ($urandom_range(0, 31) == 0);
            step("rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
